// File: rtl/reg_file_top.sv
// Register bank with one shared address bus, a synchronous write port and a registered read port.
// Addresses at or above DEPTH are unmapped: writes to them are dropped and reads from them return zero.
module reg_file_top #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    // One extra bit so the bound still fits when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_BOUND = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] regs_q   [DEPTH];
    logic [DATA_W-1:0] regs_d   [DEPTH];
    logic [DATA_W-1:0] rd_out_q;
    logic [DATA_W-1:0] rd_out_d;

    logic              addr_mapped;
    logic              wr_hit;
    logic [DEPTH-1:0]  wr_sel;
    logic [DATA_W-1:0] rd_word;

    assign addr_mapped = ({1'b0, addr} < DEPTH_BOUND);
    assign wr_hit      = write_en && addr_mapped;

    // One-hot register select plus the read mux. Both are built by comparing
    // against each implemented index, so an unmapped address selects nothing
    // and the read mux falls back to zero.
    always_comb begin
        wr_sel  = '0;
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, addr} == i[ADDR_W:0]) begin
                wr_sel[i] = wr_hit;
                rd_word   = regs_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = wr_sel[i] ? data_in : regs_q[i];
        end
    end

    // A same-cycle write to a mapped address is forwarded to the read port.
    always_comb begin
        rd_out_d = rd_out_q;
        if (read_en) begin
            rd_out_d = wr_hit ? data_in : rd_word;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments, so
    // every flop samples the values that existed before this edge.
    // NOTE: the storage array is reset along with data_out because the bank must
    // read back zero after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rd_out_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_out_q <= rd_out_d;
        end
    end

    assign data_out = rd_out_q;

endmodule

// File: tb/tb_reg_file_top.sv
// Self-checking bench for reg_file_top: directed scenarios followed by random traffic,
// all compared against a behavioural model of the register bank.
module tb_reg_file_top;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              write_en;
    logic              read_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    int errors = 0;
    int checks = 0;

    // Behavioural model: the register contents and the expected read-port value.
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] model_out;

    reg_file_top #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .read_en  (read_en),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic we, input logic re,
                              input int a, input logic [DATA_W-1:0] d);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            model_out = '0;
        end else begin
            if (re) begin
                if (a < DEPTH) model_out = we ? d : model_mem[a];
                else           model_out = '0;
            end
            if (we && a < DEPTH) model_mem[a] = d;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input string tag, input logic r, input logic we, input logic re,
                         input int a, input logic [DATA_W-1:0] d);
        rst      = r;
        write_en = we;
        read_en  = re;
        addr     = a[ADDR_W-1:0];
        data_in  = d;
        @(posedge clk);
        #1;
        model_step(r, we, re, a, d);
        check(tag, data_out, model_out);
    endtask

    task automatic do_reset();
        cycle("reset", 1'b1, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < DEPTH; i++) cycle(tag, 1'b0, 1'b0, 1'b1, i, 16'h5A5A);
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        rst = 1'b1; write_en = 1'b0; read_en = 1'b0; addr = '0; data_in = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;
        model_out = 'x;
        @(negedge clk);

        // Reset state, and reads of a freshly reset bank.
        do_reset();
        check("reset_out_zero", data_out, 16'h0000);
        read_all("fresh_read");

        // Fill with AAAA+i and read back in order.
        for (int i = 0; i < DEPTH; i++) begin
            v = 16'hAAAA + 16'(i);
            cycle("fill_a", 1'b0, 1'b1, 1'b0, i, v);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle("read_a", 1'b0, 1'b0, 1'b1, i, '0);
            v = 16'hAAAA + 16'(i);
            check("read_a_const", data_out, v);
        end

        // Write-through on a simultaneous read and write.
        cycle("wthru", 1'b0, 1'b1, 1'b1, 2, 16'h1111);
        check("wthru_const", data_out, 16'h1111);
        cycle("wthru_later", 1'b0, 1'b0, 1'b1, 2, '0);
        check("wthru_later_const", data_out, 16'h1111);

        // Unmapped addresses: writes dropped, reads zero, mapped registers untouched.
        cycle("unmap_wr14", 1'b0, 1'b1, 1'b0, 14, 16'hBEEF);
        cycle("unmap_wr15", 1'b0, 1'b1, 1'b0, 15, 16'hBEEF);
        cycle("unmap_rd14", 1'b0, 1'b0, 1'b1, 14, '0);
        check("unmap_rd14_const", data_out, 16'h0000);
        cycle("unmap_rd15", 1'b0, 1'b0, 1'b1, 15, '0);
        check("unmap_rd15_const", data_out, 16'h0000);
        cycle("unmap_wthru15", 1'b0, 1'b1, 1'b1, 15, 16'hBEEF);
        check("unmap_wthru15_const", data_out, 16'h0000);
        read_all("after_unmap");

        // Reset with a write pending: the write is discarded and everything clears.
        cycle("rst_with_wr", 1'b1, 1'b1, 1'b1, 5, 16'hDEAD);
        check("rst_with_wr_const", data_out, 16'h0000);
        read_all("after_rst");

        // Fill with F0F0+i and read with read_en toggling; data_out holds on idle cycles.
        for (int i = 0; i < DEPTH; i++) begin
            v = 16'hF0F0 + 16'(i);
            cycle("fill_f", 1'b0, 1'b1, 1'b0, i, v);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle("toggle_rd", 1'b0, 1'b0, 1'b1, i, '0);
            v = 16'hF0F0 + 16'(i);
            check("toggle_rd_const", data_out, v);
            cycle("toggle_hold", 1'b0, 1'b0, 1'b0, (i + 7) % 16, 16'h0BAD);
            check("toggle_hold_const", data_out, v);
        end

        // Random traffic, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            cycle("random",
                  ($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)),
                  16'($urandom));
        end
        read_all("final_sweep");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_top.md
# reg_file_top

16-bit, 14-entry register bank with a single shared address bus, one synchronous write port and one registered read port. It is the storage block behind the register-access path, and the reference model (scoreboard) checks it cycle by cycle. Addresses 14 and 15 are unmapped: writes to them are dropped, and reads from them return zero.

## Interface
- DATA_W, default 16: data width of each register and of the data ports.
- ADDR_W, default 4: address width.
- DEPTH, default 14: number of implemented registers, at addresses 0..DEPTH-1.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- write_en  input  1  write strobe; writes data_in to reg[addr] on the rising edge.
- read_en  input  1  read strobe; loads data_out from reg[addr] on the rising edge.
- addr  input  ADDR_W  shared read/write address.
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.

## Operation
- Storage is reg[0..13], each DATA_W bits. No storage exists for addresses 14 and 15.
- Write: if write_en=1 and addr<DEPTH, reg[addr] takes data_in at the edge. If addr>=DEPTH, the write is silently ignored.
- Read: if read_en=1, data_out takes the following at the edge:
  - data_in, if write_en=1 and addr<DEPTH (write-through for a same-cycle write).
  - Otherwise reg[addr], if addr<DEPTH.
  - Otherwise 0 (unmapped address).
- If read_en=0, data_out holds its previous value.
- Simultaneous read and write always target the same address, because the address bus is shared. The write-through rule means the new data appears on data_out.
- Reset, when rst=1 at an edge:
  - All reg[i] and data_out are set to 0.
  - Reset has priority over write_en and read_en in the same cycle.
- There is no error flag or handshake; every request completes in one cycle.
- There is no arithmetic; data is passed through unmodified at full DATA_W.

## Timing
- Write latency is 1 edge: a value written at edge N can be read by a read_en at edge N+1 or later.
- Read latency is 1 edge: addr and read_en are sampled at edge N, and data_out is valid after edge N and stable until the next read or reset.
- Reset is synchronous and takes effect at the first edge with rst=1.
  - data_out reads 0 from that edge.
  - Every register reads 0 afterward until it is rewritten.
- Reset in mid-operation:
  - A write or read in the same cycle as rst=1 is discarded.
  - Operations resume at the first edge with rst=0.
- Registers hold their values indefinitely while write_en=0.

## Test plan
- Reset, then write 16'hAAAA+i to addr i for i=0..13, then read each with write_en=0 and read_en=1 -> data_out = 16'hAAAA+i, one cycle after each address.
- Write 16'h1111 to addr 2 with read_en=1 in the same cycle -> data_out = 16'h1111 after that edge; a later read of addr 2 also returns 16'h1111.
- Write 16'hBEEF to addr 14 and to addr 15, then read both -> data_out = 16'h0000; a read of addrs 0..13 shows none of them changed.
- Fill all 14 registers, assert rst for one cycle with write_en=1, then read addrs 0..13 with write_en=0 -> every read = 16'h0000, and data_out = 0 directly after reset.
- Reset, then read_en=1 over addrs 0..13 with no writes -> all reads = 16'h0000.
- Write 16'hF0F0+i to addrs 0..13, then read with read_en toggling 1/0 -> data_out updates only on read_en=1 cycles (= 16'hF0F0+i) and holds its value otherwise.
